edc_scrub_arb: RTL
==================

# edc_scrub_arb

Background scrubber and bus arbiter in front of the EDC-protected main memory. It shares the single Wishbone path into the EDC block between the host (Amber core / system bus) and an internal scrubber. The scrubber walks the whole memory, reads each 128-bit word through the ECC corrector and writes corrected data back when a single-bit error is flagged. Sits between the system Wishbone interconnect and the EDC/main-memory block, and reports error statistics.

## Interface
- WB_DWIDTH, 128, data width of host and EDC buses
- WB_SWIDTH, 16, byte-select width (WB_DWIDTH/8)
- SCRUB_INTERVAL, 1024, idle cycles between scrub operations (≥2)
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_mem_ctrl  in  1  0 = 128 MB scrub range, 1 = 32 MB
- i_scrub_en  in  1  enables background scrubbing
- i_clr_count  in  1  synchronous clear of both error counters
- i_wb_adr / i_wb_sel / i_wb_we / i_wb_dat / i_wb_cyc / i_wb_stb  in  32/WB_SWIDTH/1/WB_DWIDTH/1/1  host Wishbone request
- o_wb_dat / o_wb_ack / o_wb_err  out  WB_DWIDTH/1/1  host Wishbone response
- o_edc_adr / o_edc_sel / o_edc_we / o_edc_dat / o_edc_cyc / o_edc_stb  out  32/WB_SWIDTH/1/WB_DWIDTH/1/1  request to EDC block
- i_edc_dat / i_edc_ack / i_edc_err  in  WB_DWIDTH/1/1  EDC response (corrected data; err = uncorrectable or bus error)
- i_edc_ce  in  1  correctable error detected; valid only in the i_edc_ack cycle
- o_ce_count  out  16  corrected-error count, saturating
- o_ue_count  out  16  uncorrectable-error count, saturating
- o_pass_done  out  1  one-cycle pulse when scrub address wraps

## Operation
- FSM states: IDLE, HOST, SCR_RD, SCR_WB.
- Interval counter: increments each IDLE cycle while i_scrub_en=1; at SCRUB_INTERVAL-1 sets scrub_pend and clears. Counter cleared and held at 0 while i_scrub_en=0; scrub_pend cleared too.
- IDLE arbitration: scrub_pend=1 → SCR_RD (scrub wins, clears scrub_pend); else i_wb_cyc&i_wb_stb → HOST; else stay. Host therefore waits at most one scrub operation (read + optional writeback).
- HOST: o_edc_* mirror host inputs combinationally; o_wb_dat=i_edc_dat, o_wb_ack=i_edc_ack, o_wb_err=i_edc_err. Return to IDLE in the cycle after ack or err. Host dropping cyc before ack → IDLE, no response.
- SCR_RD: o_edc_adr=scrub_addr, we=0, sel all ones, cyc=stb=1 until i_edc_ack. On ack: capture i_edc_dat into wb_buf.
  - i_edc_err=1: o_ue_count++, no writeback, advance address, → IDLE.
  - else i_edc_ce=1: o_ce_count++, → SCR_WB.
  - else advance address, → IDLE.
- SCR_WB: o_edc_adr=scrub_addr, we=1, sel all ones, o_edc_dat=wb_buf, cyc=stb=1 until ack; then advance, → IDLE. Err during writeback: o_ue_count++.
- Address advance: scrub_addr += WB_DWIDTH/8; if result ≥ limit (0x0800_0000 or 0x0200_0000 per i_mem_ctrl) → 0 and o_pass_done=1 for one cycle. i_mem_ctrl change mid-pass handled by the same ≥ compare.
- Scrub transactions never drive o_wb_ack/o_wb_err; in non-HOST states host responses are 0.
- i_scrub_en deasserted mid-operation: current scrub op completes normally.
- i_clr_count with simultaneous increment: clear wins (count = 0).

## Timing
- Reset: state IDLE, scrub_addr 0, interval counter 0, scrub_pend 0, wb_buf 0, both counts 0, o_pass_done 0, o_edc_cyc/stb/we 0, o_wb_ack/err 0; o_edc_cyc drops immediately on reset assertion, aborting any transfer.
- Host latency: request sampled in IDLE, o_edc_stb asserted next cycle (1-cycle arbitration overhead); response passes with zero added latency.
- Scrub read occupies ≥1 cycle (until ack); writeback ≥1 further cycle; one IDLE cycle always separates consecutive grants.
- Counter increments and o_pass_done registered, visible cycle after the triggering ack.

## Test plan
- Reset, i_scrub_en=0, host write 0x0123…CDEF to 0x100 then read → o_wb_ack each, read data matches, o_edc_stb first seen one cycle after host stb.
- i_scrub_en=1, SCRUB_INTERVAL=4, no host → scrub reads at 0x0,0x10,0x20… spaced 5+ cycles; no o_wb_ack ever.
- Scrub read returns i_edc_ce=1 with data D → o_ce_count=1, next transaction is write of D to same address, sel=16'hFFFF.
- Scrub read returns i_edc_err=1 → o_ue_count=1, no writeback, address advances by 0x10.
- Host stb raised same cycle as scrub_pend → scrub first, host acked after scrub done; i_mem_ctrl=1 with addr 0x01FF_FFF0 → wrap to 0, o_pass_done one-cycle pulse.
- Assert i_rst_n low during SCR_WB → o_edc_cyc=0 immediately, counts 0, restart at address 0.

Source files
------------

// File: rtl/edc_scrub_arb.sv
// edc_scrub_arb: shares the single Wishbone path into the EDC/main-memory
// block between the host bus and a background scrubber. The scrubber reads
// each 128-bit word through the ECC corrector, writes corrected data back on
// a correctable error, and keeps saturating error statistics.
module edc_scrub_arb #(
   parameter int          WB_DWIDTH      = 128,
   parameter int          WB_SWIDTH      = 16,
   parameter int          SCRUB_INTERVAL = 1024,
   parameter logic [31:0] LIMIT_128MB    = 32'h0800_0000,
   parameter logic [31:0] LIMIT_32MB     = 32'h0200_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_mem_ctrl,
   input  logic                 i_scrub_en,
   input  logic                 i_clr_count,
   input  logic [31:0]          i_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_wb_sel,
   input  logic                 i_wb_we,
   input  logic [WB_DWIDTH-1:0] i_wb_dat,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   output logic [WB_DWIDTH-1:0] o_wb_dat,
   output logic                 o_wb_ack,
   output logic                 o_wb_err,
   output logic [31:0]          o_edc_adr,
   output logic [WB_SWIDTH-1:0] o_edc_sel,
   output logic                 o_edc_we,
   output logic [WB_DWIDTH-1:0] o_edc_dat,
   output logic                 o_edc_cyc,
   output logic                 o_edc_stb,
   input  logic [WB_DWIDTH-1:0] i_edc_dat,
   input  logic                 i_edc_ack,
   input  logic                 i_edc_err,
   input  logic                 i_edc_ce,
   output logic [15:0]          o_ce_count,
   output logic [15:0]          o_ue_count,
   output logic                 o_pass_done
);

   localparam int              CNT_W     = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);
   localparam logic [31:0]     ADDR_STEP = 32'(WB_DWIDTH / 8);

   typedef enum logic [1:0] {IDLE, HOST, SCR_RD, SCR_WB} state_t;

   state_t               state_q, state_d;
   logic [31:0]          scrub_addr_q, scrub_addr_d;
   logic [CNT_W-1:0]     ivl_cnt_q, ivl_cnt_d;
   logic                 scrub_pend_q, scrub_pend_d;
   logic [WB_DWIDTH-1:0] wb_buf_q, wb_buf_d;
   logic [15:0]          ce_cnt_q, ce_cnt_d;
   logic [15:0]          ue_cnt_q, ue_cnt_d;
   logic                 pass_done_q, pass_done_d;

   logic                 edc_done;
   logic [31:0]          addr_inc;
   logic [31:0]          addr_limit;
   logic                 scrub_take;
   logic                 advance;
   logic                 ce_inc;
   logic                 ue_inc;

   assign edc_done   = i_edc_ack | i_edc_err;
   assign addr_inc   = scrub_addr_q + ADDR_STEP;
   assign addr_limit = i_mem_ctrl ? LIMIT_32MB : LIMIT_128MB;

   // Arbitration FSM: next state, EDC request and host response muxing.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      wb_buf_d   = wb_buf_q;
      scrub_take = 1'b0;
      advance    = 1'b0;
      ce_inc     = 1'b0;
      ue_inc     = 1'b0;
      o_edc_adr  = '0;
      o_edc_sel  = '0;
      o_edc_we   = 1'b0;
      o_edc_dat  = '0;
      o_edc_cyc  = 1'b0;
      o_edc_stb  = 1'b0;
      o_wb_dat   = '0;
      o_wb_ack   = 1'b0;
      o_wb_err   = 1'b0;

      case (state_q)
         IDLE: begin
            // A pending scrub always beats the host, bounding host wait to one op.
            if (scrub_pend_q) begin
               scrub_take = 1'b1;
               state_d    = SCR_RD;
            end else if (i_wb_cyc && i_wb_stb) begin
               state_d = HOST;
            end
         end
         HOST: begin
            o_edc_adr = i_wb_adr;
            o_edc_sel = i_wb_sel;
            o_edc_we  = i_wb_we;
            o_edc_dat = i_wb_dat;
            o_edc_cyc = i_wb_cyc;
            o_edc_stb = i_wb_stb;
            o_wb_dat  = i_edc_dat;
            o_wb_ack  = i_edc_ack;
            o_wb_err  = i_edc_err;
            if (!i_wb_cyc || edc_done) state_d = IDLE;
         end
         SCR_RD: begin
            o_edc_adr = scrub_addr_q;
            o_edc_sel = '1;
            o_edc_cyc = 1'b1;
            o_edc_stb = 1'b1;
            if (i_edc_ack) wb_buf_d = i_edc_dat;
            if (i_edc_err) begin
               ue_inc  = 1'b1;
               advance = 1'b1;
               state_d = IDLE;
            end else if (i_edc_ack) begin
               if (i_edc_ce) begin
                  ce_inc  = 1'b1;
                  state_d = SCR_WB;
               end else begin
                  advance = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         SCR_WB: begin
            o_edc_adr = scrub_addr_q;
            o_edc_sel = '1;
            o_edc_we  = 1'b1;
            o_edc_dat = wb_buf_q;
            o_edc_cyc = 1'b1;
            o_edc_stb = 1'b1;
            if (edc_done) begin
               ue_inc  = i_edc_err;
               advance = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scrub pacing, address walk and error statistics.
   always_comb begin
      ivl_cnt_d    = ivl_cnt_q;
      scrub_pend_d = scrub_pend_q & ~scrub_take;
      scrub_addr_d = scrub_addr_q;
      pass_done_d  = 1'b0;
      ce_cnt_d     = ce_cnt_q;
      ue_cnt_d     = ue_cnt_q;

      if (!i_scrub_en) begin
         ivl_cnt_d    = '0;
         scrub_pend_d = 1'b0;
      end else if (state_q == IDLE) begin
         if (ivl_cnt_q == CNT_LAST) begin
            ivl_cnt_d    = '0;
            scrub_pend_d = 1'b1;
         end else begin
            ivl_cnt_d = ivl_cnt_q + 1'b1;
         end
      end

      // The >= compare also catches a range shrink (i_mem_ctrl) mid-pass.
      if (advance) begin
         if (addr_inc >= addr_limit) begin
            scrub_addr_d = '0;
            pass_done_d  = 1'b1;
         end else begin
            scrub_addr_d = addr_inc;
         end
      end

      if (i_clr_count) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else begin
         if (ce_inc && ce_cnt_q != 16'hFFFF) ce_cnt_d = ce_cnt_q + 16'd1;
         if (ue_inc && ue_cnt_q != 16'hFFFF) ue_cnt_d = ue_cnt_q + 16'd1;
      end
   end

   // State registers; reset returns to IDLE, which drops o_edc_cyc at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         scrub_addr_q <= '0;
         ivl_cnt_q    <= '0;
         scrub_pend_q <= 1'b0;
         wb_buf_q     <= '0;
         ce_cnt_q     <= '0;
         ue_cnt_q     <= '0;
         pass_done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q      <= state_d;
         scrub_addr_q <= scrub_addr_d;
         ivl_cnt_q    <= ivl_cnt_d;
         scrub_pend_q <= scrub_pend_d;
         wb_buf_q     <= wb_buf_d;
         ce_cnt_q     <= ce_cnt_d;
         ue_cnt_q     <= ue_cnt_d;
         pass_done_q  <= pass_done_d;
      end
   end

   assign o_ce_count  = ce_cnt_q;
   assign o_ue_count  = ue_cnt_q;
   assign o_pass_done = pass_done_q;

endmodule
